// File: rtl/float_sp_pkg.sv
// Shared single-precision float definitions used by the float<->fixed converters.
package float_sp_pkg;

  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned MANT_W   = 23;
  localparam int unsigned EXP_W    = 8;
  localparam int unsigned SIG_W    = MANT_W + 1;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [2:0] {ZERO, DENORM, NORMAL, INF, NAN} fp_class_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sig;   // significand with the hidden bit made explicit
    fp_class_e        cls;
  } fp_unpacked_t;

  // Split a raw IEEE-754 single into fields and classify it.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] f);
    fp_unpacked_t u;
    u.sign = f[31];
    u.exp  = f[30:23];
    u.sig  = {|f[30:23], f[22:0]};
    if (f[30:23] == '0) begin
      u.cls = (f[22:0] == '0) ? ZERO : DENORM;
    end else if (&f[30:23]) begin
      u.cls = (f[22:0] == '0) ? INF : NAN;
    end else begin
      u.cls = NORMAL;
    end
    return u;
  endfunction

endpackage

// File: rtl/float_to_fixed_sp_if.sv
// Valid/ready bus between the float producer, the converter and the fixed-point consumer.
interface float_to_fixed_sp_if;

  logic        i_VALID;
  logic        o_READY;
  logic [31:0] i_FLOAT_WORD;
  logic        o_VALID;
  logic        i_READY;
  logic [31:0] o_FIXED_WORD;
  logic        o_INVALID;
  logic        o_OVERFLOW;
  logic        o_INEXACT;

  modport master (
    output i_VALID, i_FLOAT_WORD, i_READY,
    input  o_READY, o_VALID, o_FIXED_WORD, o_INVALID, o_OVERFLOW, o_INEXACT
  );

  modport slave (
    input  i_VALID, i_FLOAT_WORD, i_READY,
    output o_READY, o_VALID, o_FIXED_WORD, o_INVALID, o_OVERFLOW, o_INEXACT
  );

endinterface

// File: rtl/fp_align_shift.sv
// Bidirectional barrel shifter: scales a 24-bit significand by 2^shift into a 32-bit magnitude,
// keeping guard/sticky on right shifts and flagging left shifts that cannot fit.
module fp_align_shift
  import float_sp_pkg::*;
(
  input  logic [SIG_W-1:0]  sig,
  input  logic signed [9:0] shift,
  output logic [31:0]       mag,
  output logic              guard,
  output logic              sticky,
  output logic              left_ovf
);

  localparam int unsigned RightMax = SIG_W + 1;  // beyond this every bit is below the guard

  logic [9:0]                rsh;
  logic [SIG_W+RightMax-1:0] ext;

  // Select left or right alignment; right shifts carry the significand into guard/sticky bits.
  always_comb begin
    mag      = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    left_ovf = 1'b0;
    rsh      = '0;
    ext      = '0;
    if (!shift[9]) begin
      // sig << 8 already reaches bit 31; anything larger is out of range for sure.
      if (shift > 10'sd8) begin
        left_ovf = 1'b1;
      end else begin
        mag = {8'b0, sig} << shift[3:0];
      end
    end else begin
      rsh = -shift;
      if (rsh > 10'(RightMax)) begin
        sticky = |sig;
      end else begin
        ext    = {sig, {RightMax{1'b0}}} >> rsh[4:0];
        mag    = {8'b0, ext[SIG_W+RightMax-1:RightMax]};
        guard  = ext[RightMax-1];
        sticky = |ext[RightMax-2:0];
      end
    end
  end

endmodule

// File: rtl/float_to_fixed_sp.sv
// Three-stage float32 -> Q(31-FRAC_BITS).FRAC_BITS converter: unpack, align, round/saturate.
module float_to_fixed_sp
  import float_sp_pkg::*;
#(
  parameter int unsigned FRAC_BITS = 0
) (
  input logic                i_CLK,
  input logic                i_RST,
  float_to_fixed_sp_if.slave bus
);

  localparam int                ShiftBias = int'(FRAC_BITS) - int'(EXP_BIAS) - int'(MANT_W);
  localparam logic signed [9:0] ShiftOfs  = 10'(ShiftBias);

  logic en;

  logic         s1_valid_q;
  fp_unpacked_t s1_q;

  logic signed [9:0] s2_shift;
  logic [31:0]       al_mag;
  logic              al_guard, al_sticky, al_lovf;

  logic        s2_valid_q, s2_sign_q, s2_guard_q, s2_sticky_q, s2_lovf_q;
  fp_class_e   s2_cls_q;
  logic [31:0] s2_mag_q;

  logic [32:0] rounded;
  logic        round_up, too_big, exact_min;
  logic [31:0] out_word_d, out_word_q;
  logic        out_inv_d, out_inv_q, out_ovf_d, out_ovf_q, out_inx_d, out_inx_q;
  logic        out_valid_q;

  // A single enable stalls every stage together whenever the held result is not taken.
  assign en          = !out_valid_q || bus.i_READY;
  assign bus.o_READY = en;

  // Stage 1: capture and classify the incoming float.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (en) begin
      s1_valid_q <= bus.i_VALID;
      s1_q       <= fp_unpack(bus.i_FLOAT_WORD);
    end
  end

  assign s2_shift = ShiftOfs + $signed({2'b00, s1_q.exp});

  fp_align_shift u_align (
    .sig      (s1_q.sig),
    .shift    (s2_shift),
    .mag      (al_mag),
    .guard    (al_guard),
    .sticky   (al_sticky),
    .left_ovf (al_lovf)
  );

  // Stage 2: register the aligned magnitude and rounding bits.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= ZERO;
      s2_mag_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_lovf_q   <= 1'b0;
    end else if (en) begin
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_q.sign;
      s2_cls_q    <= s1_q.cls;
      s2_mag_q    <= al_mag;
      s2_guard_q  <= al_guard;
      s2_sticky_q <= al_sticky;
      s2_lovf_q   <= al_lovf;
    end
  end

  assign round_up  = s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
  assign rounded   = {1'b0, s2_mag_q} + {32'b0, round_up};
  assign too_big   = rounded[32] | rounded[31];
  // -2^31 is the one magnitude at 2^31 that still fits.
  assign exact_min = s2_sign_q && (rounded == 33'h0_8000_0000);

  // Stage 3 next state: round half-to-even, saturate, negate, and pick special results.
  always_comb begin
    out_word_d = '0;
    out_inv_d  = 1'b0;
    out_ovf_d  = 1'b0;
    out_inx_d  = 1'b0;
    unique case (s2_cls_q)
      NAN: out_inv_d = 1'b1;
      INF: begin
        out_inv_d  = 1'b1;
        out_word_d = s2_sign_q ? INT32_MIN : INT32_MAX;
      end
      DENORM: out_inx_d = 1'b1;
      NORMAL: begin
        if (s2_lovf_q || (too_big && !exact_min)) begin
          out_ovf_d  = 1'b1;
          out_word_d = s2_sign_q ? INT32_MIN : INT32_MAX;
        end else begin
          out_word_d = s2_sign_q ? (~rounded[31:0] + 32'd1) : rounded[31:0];
          out_inx_d  = s2_guard_q | s2_sticky_q;
        end
      end
      default: out_word_d = '0;
    endcase
  end

  // Stage 3: output register.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_inv_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_valid_q;
      out_word_q  <= out_word_d;
      out_inv_q   <= out_inv_d;
      out_ovf_q   <= out_ovf_d;
      out_inx_q   <= out_inx_d;
    end
  end

  assign bus.o_VALID      = out_valid_q;
  assign bus.o_FIXED_WORD = out_word_q;
  assign bus.o_INVALID    = out_inv_q;
  assign bus.o_OVERFLOW   = out_ovf_q;
  assign bus.o_INEXACT    = out_inx_q;

endmodule

// File: tb/tb_float_to_fixed_sp.sv
// Self-checking bench: two converters (FRAC_BITS 0 and 16) fed the same stream and
// scored against a real-arithmetic reference model.
module tb_float_to_fixed_sp;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  flags;  // {invalid, overflow, inexact}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = '0;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int out_cnt0 = 0;
  int out_cnt16 = 0;
  exp_t q0[$];
  exp_t q16[$];

  float_to_fixed_sp_if bus0 ();
  float_to_fixed_sp_if bus16 ();

  assign bus0.i_VALID       = in_valid;
  assign bus0.i_FLOAT_WORD  = in_word;
  assign bus0.i_READY       = out_ready;
  assign bus16.i_VALID      = in_valid;
  assign bus16.i_FLOAT_WORD = in_word;
  assign bus16.i_READY      = out_ready;

  float_to_fixed_sp #(.FRAC_BITS(0)) dut0 (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus0)
  );

  float_to_fixed_sp #(.FRAC_BITS(16)) dut16 (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus16)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic real pow2(input int p);
    real v = 1.0;
    if (p >= 0) for (int i = 0; i < p; i++) v = v * 2.0;
    else        for (int i = 0; i < -p; i++) v = v * 0.5;
    return v;
  endfunction

  // Reference: exact value = 1.m * 2^(e-127) * 2^frac, rounded half-to-even in real arithmetic.
  function automatic exp_t model(input logic [31:0] f, input int frac);
    exp_t   r;
    real    x, fl, d;
    longint lv, lim;
    int     e;
    e = int'(f[30:23]);
    r.word  = '0;
    r.flags = '0;
    if (e == 255) begin
      r.flags = 3'b100;
      if (f[22:0] == 0) r.word = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e == 0) begin
      r.flags = {2'b00, f[22:0] != 0};
    end else begin
      x = real'({1'b1, f[22:0]}) * pow2(e - 150 + frac);
      lim = f[31] ? 64'sd2147483648 : 64'sd2147483647;
      if (x >= 4294967296.0) begin
        lv = lim + 1;
        d  = 0.0;
      end else begin
        fl = $floor(x);
        d  = x - fl;
        lv = longint'(fl);
        if (d > 0.5 || (d == 0.5 && lv[0])) lv++;
      end
      if (lv > lim) begin
        r.flags = 3'b010;
        r.word  = f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        r.word  = f[31] ? 32'(-lv) : 32'(lv);
        r.flags = {2'b00, d != 0.0};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [7:0]  e;
    logic [22:0] m;
    int          sel;
    sel = $urandom_range(0, 19);
    m   = 23'($urandom);
    if ($urandom_range(0, 1) == 1) m = m & (23'h7FFFFF << $urandom_range(0, 22));
    case (sel)
      0:       begin e = 8'd0;   if ($urandom_range(0, 1) == 1) m = '0; end
      1:       begin e = 8'd255; if ($urandom_range(0, 1) == 1) m = '0; end
      2:       begin e = 8'($urandom_range(156, 160)); m = m & 23'h00000F; end
      default: e = 8'($urandom_range(96, 175));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // Scoreboard: while a result is presented it must equal the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) begin
      q0.delete();
      q16.delete();
    end else begin
      if (bus0.o_VALID) begin
        if (q0.size() == 0) check_eq("spurious_valid0", 32'(bus0.o_VALID), 32'd0);
        else begin
          check_eq("word0", bus0.o_FIXED_WORD, q0[0].word);
          check_eq("flags0", 32'({bus0.o_INVALID, bus0.o_OVERFLOW, bus0.o_INEXACT}),
                   32'(q0[0].flags));
          if (out_ready) begin
            q0.delete(0);
            out_cnt0++;
          end
        end
      end
      if (bus16.o_VALID) begin
        if (q16.size() == 0) check_eq("spurious_valid16", 32'(bus16.o_VALID), 32'd0);
        else begin
          check_eq("word16", bus16.o_FIXED_WORD, q16[0].word);
          check_eq("flags16", 32'({bus16.o_INVALID, bus16.o_OVERFLOW, bus16.o_INEXACT}),
                   32'(q16[0].flags));
          if (out_ready) begin
            q16.delete(0);
            out_cnt16++;
          end
        end
      end
      if (in_valid && bus0.o_READY)  q0.push_back(model(in_word, 0));
      if (in_valid && bus16.o_READY) q16.push_back(model(in_word, 16));
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (q0.size() + q16.size()) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain_empty", 32'(q0.size() + q16.size()), 32'd0);
  endtask

  task automatic directed(input string tag, input logic [31:0] w, input logic [31:0] want_w,
                          input logic [2:0] want_f, input bit use16);
    int lat;
    bit seen;
    in_word   = w;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      #1;
      lat++;
      seen = use16 ? bus16.o_VALID : bus0.o_VALID;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd3);
    if (use16) begin
      check_eq({tag, "_word"}, bus16.o_FIXED_WORD, want_w);
      check_eq({tag, "_flags"}, 32'({bus16.o_INVALID, bus16.o_OVERFLOW, bus16.o_INEXACT}),
               32'(want_f));
    end else begin
      check_eq({tag, "_word"}, bus0.o_FIXED_WORD, want_w);
      check_eq({tag, "_flags"}, 32'({bus0.o_INVALID, bus0.o_OVERFLOW, bus0.o_INEXACT}),
               32'(want_f));
    end
    drain();
  endtask

  initial begin
    logic [31:0] ws[8];
    int          idx, start;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_valid", 32'(bus0.o_VALID), 32'd0);
    check_eq("rst_word", bus0.o_FIXED_WORD, 32'd0);
    check_eq("rst_flags", 32'({bus0.o_INVALID, bus0.o_OVERFLOW, bus0.o_INEXACT}), 32'd0);
    check_eq("rst_ready", 32'(bus0.o_READY), 32'd1);

    directed("one",      32'h3F80_0000, 32'h0000_0001, 3'b000, 1'b0);
    directed("m32",      32'hC200_0000, 32'hFFFF_FFE0, 3'b000, 1'b0);
    directed("p2_5",     32'h4020_0000, 32'h0000_0002, 3'b001, 1'b0);
    directed("p3_5",     32'h4060_0000, 32'h0000_0004, 3'b001, 1'b0);
    directed("m1_5",     32'hBFC0_0000, 32'hFFFF_FFFE, 3'b001, 1'b0);
    directed("p2e31",    32'h4F00_0000, 32'h7FFF_FFFF, 3'b010, 1'b0);
    directed("m2e31",    32'hCF00_0000, 32'h8000_0000, 3'b000, 1'b0);
    directed("nan",      32'h7FC0_0000, 32'h0000_0000, 3'b100, 1'b0);
    directed("ninf",     32'hFF80_0000, 32'h8000_0000, 3'b100, 1'b0);
    directed("denorm",   32'h0000_0001, 32'h0000_0000, 3'b001, 1'b0);
    directed("q16_1_5",  32'h3FC0_0000, 32'h0001_8000, 3'b000, 1'b1);

    // Eight back-to-back words with a four-cycle downstream stall in the middle.
    for (int i = 0; i < 8; i++) ws[i] = rand_word();
    idx   = 0;
    start = out_cnt0;
    for (int t = 0; t < 40 && idx < 8; t++) begin
      out_ready = !(t >= 5 && t < 9);
      in_valid  = 1'b1;
      in_word   = ws[idx];
      @(negedge clk);
      if (!out_ready) check_eq("stall_ready", 32'(bus0.o_READY), 32'd0);
      if (bus0.o_READY) idx++;
      @(posedge clk);
      #1;
    end
    drain();
    check_eq("stall_count", 32'(out_cnt0 - start), 32'd8);

    // Reset with three words in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_word  = rand_word();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("post_rst_valid", 32'(bus0.o_VALID), 32'd0);
    check_eq("post_rst_ready", 32'(bus0.o_READY), 32'd1);
    start    = out_cnt0;
    in_valid = 1'b1;
    in_word  = 32'h4040_0000;  // 3.0
    @(negedge clk);
    check_eq("post_rst_accept", 32'(bus0.o_READY), 32'd1);
    @(posedge clk);
    #1;
    drain();
    check_eq("post_rst_count", 32'(out_cnt0 - start), 32'd1);

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_word   = rand_word();
      out_ready = ($urandom_range(0, 4) != 0);
      @(posedge clk);
      #1;
    end
    drain();
    check_eq("final_count", 32'(out_cnt16), 32'(out_cnt0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
